fifo_rd_stream: RTL and testbench

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_stream_if.sv | 30 +++
 rtl/fifo_rd_stream.sv | 88 ++++++++
 tb/tb_fifo_rd_stream.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_stream_if.sv
// Bundle of signals between fifo_rd_stream, its upstream FIFO read port and its downstream stream.
// The master modport is the streamer's view; the slave modport is the view of whatever surrounds it.
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 8
);
  // Handshake semantics:
  //   upstream:   a word is popped on every rising edge where fifo_ren=1.
  //               fifo_ren is never asserted while fifo_empty=1.
  //   downstream: a beat transfers on every rising edge where m_valid && m_ready.
  //               Once m_valid is raised, it stays high with m_data and m_last stable until that edge.
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_ren;
  logic                  flush;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic [1:0]            occ;

  modport master (
    input  fifo_empty, fifo_rdata, flush, m_ready,
    output fifo_ren, m_valid, m_data, m_last, occ
  );

  modport slave (
    output fifo_empty, fifo_rdata, flush, m_ready,
    input  fifo_ren, m_valid, m_data, m_last, occ
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Pops an upstream FIFO into a 2-entry registered skid buffer and presents it as a valid/ready
// stream, tagging the final beat of every BURST_LEN-beat burst with m_last.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic             clk,
  input  logic             rst,
  fifo_rd_stream_if.master bus
);
  localparam int            BW       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] BEAT_MAX = BW'(BURST_LEN - 1);

  logic [DATA_WIDTH-1:0] ent0_q, ent0_d;
  logic [DATA_WIDTH-1:0] ent1_q, ent1_d;
  logic [1:0]            occ_q, occ_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  push;
  logic                  pop;

  // Refill decision looks only at local occupancy, so m_ready never reaches fifo_ren.
  assign push         = !bus.fifo_empty && (occ_q != 2'd2) && !bus.flush && !rst;
  assign pop          = valid_q && bus.m_ready;
  assign bus.fifo_ren = push;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    beat_d = beat_q;
    if (bus.flush) begin
      occ_d  = 2'd0;
      beat_d = '0;
    end else begin
      if (pop) begin
        beat_d = (beat_q == BEAT_MAX) ? '0 : beat_q + BW'(1);
      end
      // ent0 is always the head; ent1 only holds a word while occ is 2.
      unique case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) ent0_d = bus.fifo_rdata;
          else               ent1_d = bus.fifo_rdata;
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          ent0_d = ent1_q;
          occ_d  = occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd2) begin
            ent0_d = ent1_q;
            ent1_d = bus.fifo_rdata;
          end else begin
            ent0_d = bus.fifo_rdata;
          end
        end
        default: ;
      endcase
    end
    valid_d = (occ_d != 2'd0);
    last_d  = valid_d && (beat_d == BEAT_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      occ_q   <= 2'd0;
      beat_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      occ_q   <= occ_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign bus.m_valid = valid_q;
  assign bus.m_last  = last_q;
  assign bus.m_data  = ent0_q;
  assign bus.occ     = occ_q;
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: a BURST_LEN=4 instance for stream, backpressure, gap, flush and
// reset scenarios, plus a BURST_LEN=1 instance for the single-beat burst case.
module tb_fifo_rd_stream;
  localparam int W  = 8;
  localparam int SW = W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_rd_stream_if #(.DATA_WIDTH(W)) bus0 ();
  fifo_rd_stream_if #(.DATA_WIDTH(W)) bus1 ();

  fifo_rd_stream #(.DATA_WIDTH(W), .BURST_LEN(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  fifo_rd_stream #(.DATA_WIDTH(W), .BURST_LEN(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // ---------------- upstream FIFO models and scoreboard ----------------
  logic [W-1:0]  src0_q[$];
  logic [W-1:0]  src1_q[$];
  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] exp1_q[$];
  int errors    = 0;
  int checks    = 0;
  int push0_cnt = 0;
  int xfer0_cnt = 0;
  int p0;
  int x0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    bus0.fifo_empty = (src0_q.size() == 0);
    bus0.fifo_rdata = (src0_q.size() == 0) ? '0 : src0_q[0];
    bus1.fifo_empty = (src1_q.size() == 0);
    bus1.fifo_rdata = (src1_q.size() == 0) ? '0 : src1_q[0];
  endtask

  task automatic exp0(input logic last, input logic [W-1:0] d);
    exp_q.push_back({last, d});
  endtask

  task automatic exp1(input logic last, input logic [W-1:0] d);
    exp1_q.push_back({last, d});
  endtask

  // One clock: sample handshakes mid-cycle, then after the edge pop the FIFO models and score transfers.
  task automatic tick();
    logic          ren0, ren1, xf0, xf1;
    logic [SW-1:0] got0, got1, e;
    @(negedge clk);
    ren0 = bus0.fifo_ren;
    ren1 = bus1.fifo_ren;
    xf0  = bus0.m_valid && bus0.m_ready;
    xf1  = bus1.m_valid && bus1.m_ready;
    got0 = {bus0.m_last, bus0.m_data};
    got1 = {bus1.m_last, bus1.m_data};
    @(posedge clk);
    #1;
    if (ren0) begin
      src0_q.delete(0);
      push0_cnt++;
    end
    if (ren1) src1_q.delete(0);
    if (xf0) begin
      xfer0_cnt++;
      check("xfer0_avail", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("xfer0_word", got0, e);
      end
    end
    if (xf1) begin
      check("xfer1_avail", exp1_q.size() != 0, 1);
      if (exp1_q.size() != 0) begin
        e = exp1_q.pop_front();
        check("xfer1_word", got1, e);
      end
    end
    drive_fifo();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst          = 1'b1;
    bus0.flush   = 1'b0;
    bus0.m_ready = 1'b0;
    bus1.flush   = 1'b0;
    bus1.m_ready = 1'b0;
    drive_fifo();
    repeat (2) tick();

    // Reset state, with a non-empty FIFO that must not be popped
    for (int i = 0; i < 8; i++) src0_q.push_back(W'(8'h10 + i));
    drive_fifo();
    #1;
    check("rst_occ",   bus0.occ, 0);
    check("rst_valid", bus0.m_valid, 0);
    check("rst_last",  bus0.m_last, 0);
    check("rst_data",  bus0.m_data, 0);
    check("rst_ren",   bus0.fifo_ren, 0);

    // Stream 0x10..0x17 at full rate
    rst          = 1'b0;
    bus0.m_ready = 1'b1;
    for (int i = 0; i < 8; i++) exp0((i % 4) == 3, W'(8'h10 + i));
    for (int i = 0; i < 8; i++) begin
      tick();
      check("stream_occ", bus0.occ, 1);
    end
    tick();
    check("stream_end_occ",   bus0.occ, 0);
    check("stream_end_valid", bus0.m_valid, 0);
    check("stream_xfers",     xfer0_cnt, 8);
    check("stream_drained",   exp_q.size(), 0);

    // Backpressure: 5 stalled cycles, then drain in order
    bus0.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) src0_q.push_back(W'(8'hA0 + i));
    drive_fifo();
    p0 = push0_cnt;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_data_hold",  bus0.m_data, 8'hA0);
      check("bp_valid_hold", bus0.m_valid, 1);
    end
    check("bp_pushes", push0_cnt - p0, 2);
    check("bp_occ",    bus0.occ, 2);
    check("bp_last",   bus0.m_last, 0);
    exp0(1'b0, 8'hA0);
    exp0(1'b0, 8'hA1);
    exp0(1'b0, 8'hA2);
    exp0(1'b1, 8'hA3);
    bus0.m_ready = 1'b1;
    repeat (4) tick();
    check("bp_drained", exp_q.size(), 0);
    check("bp_occ_end", bus0.occ, 0);

    // Underflow gap: 0x01,0x02, three empty cycles, then 0x03,0x04
    src0_q.push_back(8'h01);
    src0_q.push_back(8'h02);
    drive_fifo();
    exp0(1'b0, 8'h01);
    exp0(1'b0, 8'h02);
    exp0(1'b0, 8'h03);
    exp0(1'b1, 8'h04);
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("gap_valid", bus0.m_valid, 0);
      check("gap_ren",   bus0.fifo_ren, 0);
    end
    src0_q.push_back(8'h03);
    src0_q.push_back(8'h04);
    drive_fifo();
    repeat (3) tick();
    check("gap_drained", exp_q.size(), 0);

    // Flush at beat 2 with 0x55,0x56 buffered
    src0_q.push_back(8'h30);
    src0_q.push_back(8'h31);
    drive_fifo();
    exp0(1'b0, 8'h30);
    exp0(1'b0, 8'h31);
    repeat (3) tick();
    bus0.m_ready = 1'b0;
    src0_q.push_back(8'h55);
    src0_q.push_back(8'h56);
    src0_q.push_back(8'h57);
    drive_fifo();
    repeat (2) tick();
    check("fl_pre_occ",  bus0.occ, 2);
    check("fl_pre_data", bus0.m_data, 8'h55);
    bus0.flush = 1'b1;
    #1;
    check("fl_ren", bus0.fifo_ren, 0);
    tick();
    bus0.flush = 1'b0;
    check("fl_occ",   bus0.occ, 0);
    check("fl_valid", bus0.m_valid, 0);
    bus0.m_ready = 1'b1;
    src0_q.push_back(8'h58);
    src0_q.push_back(8'h59);
    src0_q.push_back(8'h5A);
    drive_fifo();
    exp0(1'b0, 8'h57);
    exp0(1'b0, 8'h58);
    exp0(1'b0, 8'h59);
    exp0(1'b1, 8'h5A);
    tick();
    check("fl_next_data", bus0.m_data, 8'h57);
    repeat (4) tick();
    check("fl_drained", exp_q.size(), 0);

    // Asynchronous reset after two beats of a burst
    for (int i = 0; i < 5; i++) src0_q.push_back(W'(8'h70 + i));
    drive_fifo();
    exp0(1'b0, 8'h70);
    exp0(1'b0, 8'h71);
    repeat (3) tick();
    check("mr_two_beats", exp_q.size(), 0);
    #2;
    rst = 1'b1;
    #1;
    check("mr_valid", bus0.m_valid, 0);
    check("mr_ren",   bus0.fifo_ren, 0);
    check("mr_occ",   bus0.occ, 0);
    check("mr_last",  bus0.m_last, 0);
    tick();
    rst = 1'b0;
    src0_q.push_back(8'h75);
    src0_q.push_back(8'h76);
    drive_fifo();
    exp0(1'b0, 8'h73);
    exp0(1'b0, 8'h74);
    exp0(1'b0, 8'h75);
    exp0(1'b1, 8'h76);
    tick();
    check("mr_first_valid", bus0.m_valid, 1);
    check("mr_first_data",  bus0.m_data, 8'h73);
    repeat (4) tick();
    check("mr_drained", exp_q.size(), 0);
    check("mr_occ_end", bus0.occ, 0);

    // Single-beat bursts: every beat is last
    bus1.m_ready = 1'b1;
    src1_q.push_back(8'hC1);
    src1_q.push_back(8'hC2);
    src1_q.push_back(8'hC3);
    drive_fifo();
    exp1(1'b1, 8'hC1);
    exp1(1'b1, 8'hC2);
    exp1(1'b1, 8'hC3);
    tick();
    check("bl1_last", bus1.m_last, 1);
    repeat (3) tick();
    check("bl1_drained", exp1_q.size(), 0);
    check("bl1_idle",    bus1.m_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
